sys_bus_xbar: RTL and testbench
===============================

Name: sys_bus_xbar

Overview:
- Parametrised 1-master / N-slave system-bus decoder with registered request issue, per-slave ready handshake, response capture, timeout and unmapped-address error.
- Sits between riscv_lsu (master side) and the peripheral controllers (data memory, UART rx/tx, future devices).
- Replaces the ad-hoc one-hot select and combinational read mux in the top unit.
- Slave index is taken from an address field; the field is zeroed on the address forwarded to the slave.

Parameters:
- N_SLAVES, 8, number of slave channels; slave index range 0..N_SLAVES-1.
- DATA_W, 32, data width; the byte-enable width is DATA_W/8.
- SEL_MSB, 31, top bit of the slave-select field in addr_i.
- SEL_LSB, 24, bottom bit of the slave-select field in addr_i.
- TIMEOUT, 255, BUSY cycles allowed before error; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, value returned on rd_o for an errored read.

Ports:
- clk_i  in  1  system clock.
- resetn_i  in  1  reset; synchronous, active-low.
- req_i  in  1  master request.
- we_i  in  1  master write enable.
- addr_i  in  32  master address.
- wd_i  in  DATA_W  master write data.
- be_i  in  DATA_W/8  master byte enables.
- rd_o  out  DATA_W  registered read data.
- ready_o  out  1  one-cycle completion pulse.
- err_o  out  1  error flag, qualified by ready_o.
- s_req_o  out  N_SLAVES  one-hot slave request.
- s_we_o  out  1  write enable to slaves, shared.
- s_addr_o  out  32  latched address with the select field zeroed, shared.
- s_wd_o  out  DATA_W  latched write data, shared.
- s_be_o  out  DATA_W/8  latched byte enables, shared.
- s_rd_i  in  N_SLAVES*DATA_W  flattened slave read data; slave k occupies bits [k*DATA_W +: DATA_W].
- s_ready_i  in  N_SLAVES  per-slave ready.

Behaviour:
- Reset: resetn_i is sampled at posedge clk_i; when low, everything clears on the next edge.
  - FSM goes to IDLE.
  - s_req_o=0, ready_o=0, err_o=0, rd_o=0.
  - Latched we/addr/wd/be = 0; timeout counter = 0.
  - Reset during BUSY abandons the transaction; no ready_o is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_i is sampled only in this state.
  - On req_i=1: latch we_i, addr_i, wd_i, be_i; compute sel = addr_i[SEL_MSB:SEL_LSB].
  - If sel >= N_SLAVES: go to DONE with err=1.
  - Otherwise: set s_req_o = 1<<sel and go to BUSY.
  - s_ready_i is ignored in IDLE.
- BUSY:
  - s_req_o[sel] stays high; the shared slave outputs come from the latched registers.
  - Counter increments each cycle.
  - If s_ready_i[sel]=1: on a read, capture s_rd_i[sel] into rd_o; clear s_req_o; go to DONE with err=0.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: clear s_req_o; go to DONE with err=1. This gives exactly TIMEOUT BUSY cycles.
  - Ready and timeout in the same cycle: ready wins.
  - s_ready_i from non-selected slaves is ignored.
- DONE:
  - ready_o=1 and err_o=err for exactly one cycle.
  - On an errored read, rd_o=ERR_DATA.
  - Counter clears; go to IDLE.
  - req_i is ignored in DONE. The master drops req_i the cycle after ready_o or reissues.
- rd_o hold rules:
  - Writes never change rd_o.
  - rd_o holds its last value until the next completed read, or until reset.
- Latency, req_i sampled at cycle N:
  - s_req_o rises at N+1.
  - With slave ready at N+1, ready_o is at N+2 (minimum 2 cycles).
  - Unmapped address: ready_o at N+1.
  - Timeout: ready_o at N+1+TIMEOUT.
- s_addr_o = latched addr with bits [SEL_MSB:SEL_LSB] forced to 0, all other bits passed through.
- Only one transaction is outstanding at a time; there is no pipelining.

Decomposition:
- Package sys_bus_pkg holds:
  - bus_state_t enum {IDLE, BUSY, DONE}.
  - Default ERR_DATA and DATA_W constants.
  - Select-field defaults SEL_MSB/SEL_LSB.
- No sub-module needed. The decode, FSM and counter sit in one module. The response mux is a generate-indexed part-select of s_rd_i.

Test Plan:
- Read from slave 0 at addr 32'h0000_0010, slave 0 asserts ready in its first BUSY cycle with data 32'h1234_5678 -> s_addr_o=32'h0000_0010; ready_o exactly 2 cycles after req_i; rd_o=32'h1234_5678; err_o=0.
- Write to slave 6 at addr 32'h0600_0004 with wd=32'hA5, be=4'b0001, ready after 3 BUSY cycles -> s_req_o=8'b0100_0000 for 3 cycles; s_addr_o=32'h0000_0004; ready_o pulses once; rd_o unchanged.
- Access to addr 32'h0900_0000 with N_SLAVES=8 -> no s_req_o bit set; ready_o one cycle after req_i; err_o=1; on a read rd_o=32'hDEAD_BEEF.
- TIMEOUT=4, selected slave never ready -> s_req_o high exactly 4 cycles, then ready_o with err_o=1.
- Slave 5 selected, slave 0 pulses ready in BUSY -> pulse ignored; transaction completes only on s_ready_i[5].
- resetn_i low during BUSY -> next edge: s_req_o=0, FSM in IDLE, rd_o=0, no ready_o pulse.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared types and default constants for the system-bus crossbar.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  localparam int          DEF_DATA_W   = 32;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          DEF_SEL_MSB  = 31;
  localparam int          DEF_SEL_LSB  = 24;

endpackage

// File: rtl/sys_bus_xbar.sv
// 1-master / N-slave bus decoder: latches one request, selects a slave from an
// address field, waits for that slave's ready (or a timeout) and returns a
// registered response with a one-cycle completion pulse.
module sys_bus_xbar
  import sys_bus_pkg::*;
#(
  parameter int                N_SLAVES = 8,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                SEL_MSB  = DEF_SEL_MSB,
  parameter int                SEL_LSB  = DEF_SEL_LSB,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [31:0]                addr_i,
  input  logic [DATA_W-1:0]          wd_i,
  input  logic [DATA_W/8-1:0]        be_i,
  output logic [DATA_W-1:0]          rd_o,
  output logic                       ready_o,
  output logic                       err_o,
  output logic [N_SLAVES-1:0]        s_req_o,
  output logic                       s_we_o,
  output logic [31:0]                s_addr_o,
  output logic [DATA_W-1:0]          s_wd_o,
  output logic [DATA_W/8-1:0]        s_be_o,
  input  logic [N_SLAVES*DATA_W-1:0] s_rd_i,
  input  logic [N_SLAVES-1:0]        s_ready_i
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
  // Slave index width, and the power-of-two size of the padded lookup tables
  // so that indexing with sel_reg can never run off the end.
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int IDX_N = 1 << IDX_W;
  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_SLAVES);

  bus_state_t state_reg, state_next;

  logic                 we_reg;
  logic [31:0]          addr_reg;
  logic [DATA_W-1:0]    wd_reg;
  logic [DATA_W/8-1:0]  be_reg;
  logic [IDX_W-1:0]     sel_reg;
  logic                 err_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [DATA_W-1:0]    rd_reg;

  logic [SEL_W-1:0]     sel_field;
  logic                 mapped;
  logic [31:0]          addr_masked;
  logic [DATA_W-1:0]    slave_rd [IDX_N];
  logic [IDX_N-1:0]     ready_pad;
  logic                 sel_ready;
  logic                 timeout_hit;

  assign sel_field = addr_i[SEL_MSB:SEL_LSB];
  assign mapped    = ({1'b0, sel_field} < N_LIM);

  // Select field is zeroed before latching so slaves see a local address.
  for (genvar gi = 0; gi < 32; gi++) begin : g_addr
    if (gi >= SEL_LSB && gi <= SEL_MSB) begin : g_zero
      assign addr_masked[gi] = 1'b0;
    end else begin : g_pass
      assign addr_masked[gi] = addr_i[gi];
    end
  end

  // Response mux: unpack slave read data / ready, padding unused slots.
  for (genvar gi = 0; gi < IDX_N; gi++) begin : g_slv
    if (gi < N_SLAVES) begin : g_live
      assign slave_rd[gi]  = s_rd_i[gi*DATA_W +: DATA_W];
      assign ready_pad[gi] = s_ready_i[gi];
    end else begin : g_pad
      assign slave_rd[gi]  = '0;
      assign ready_pad[gi] = 1'b0;
    end
  end

  assign sel_ready   = ready_pad[sel_reg];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  // Next-state logic; ready takes priority over timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_i) state_next = mapped ? BUSY : DONE;
      BUSY:    if (sel_ready || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, timeout counter, error flag and read-data capture.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      we_reg   <= 1'b0;
      addr_reg <= '0;
      wd_reg   <= '0;
      be_reg   <= '0;
      sel_reg  <= '0;
      err_reg  <= 1'b0;
      cnt_reg  <= '0;
      rd_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_i) begin
            we_reg   <= we_i;
            addr_reg <= addr_masked;
            wd_reg   <= wd_i;
            be_reg   <= be_i;
            sel_reg  <= sel_field[IDX_W-1:0];
            err_reg  <= !mapped;
            cnt_reg  <= '0;
            if (!mapped && !we_i) rd_reg <= ERR_DATA;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (sel_ready) begin
            err_reg <= 1'b0;
            if (!we_reg) rd_reg <= slave_rd[sel_reg];
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
            if (!we_reg) rd_reg <= ERR_DATA;
          end
        end
        DONE: cnt_reg <= '0;
        default: cnt_reg <= '0;
      endcase
    end
  end

  // Outputs decoded from state and the latched request.
  always_comb begin
    ready_o = (state_reg == DONE);
    err_o   = (state_reg == DONE) && err_reg;
    for (int k = 0; k < N_SLAVES; k++) begin
      s_req_o[k] = (state_reg == BUSY) && (sel_reg == IDX_W'(k));
    end
  end

  assign rd_o     = rd_reg;
  assign s_we_o   = we_reg;
  assign s_addr_o = addr_reg;
  assign s_wd_o   = wd_reg;
  assign s_be_o   = be_reg;

endmodule

// File: tb/tb_sys_bus_xbar.sv
// Self-checking bench for sys_bus_xbar: directed cases followed by random
// transactions, each checked cycle by cycle against a count-based model.
module tb_sys_bus_xbar;

  localparam int NS  = 8;
  localparam int DW  = 32;
  localparam int TMO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic           clk_i = 1'b0;
  logic           resetn_i;
  logic           req_i;
  logic           we_i;
  logic [31:0]    addr_i;
  logic [DW-1:0]  wd_i;
  logic [DW/8-1:0] be_i;
  logic [DW-1:0]  rd_o;
  logic           ready_o;
  logic           err_o;
  logic [NS-1:0]  s_req_o;
  logic           s_we_o;
  logic [31:0]    s_addr_o;
  logic [DW-1:0]  s_wd_o;
  logic [DW/8-1:0] s_be_o;
  logic [NS*DW-1:0] s_rd_i;
  logic [NS-1:0]  s_ready_i;

  int total = 0;
  int bad   = 0;
  int ntxn  = 0;
  logic [31:0] rd_model = '0;

  always #5 clk_i = ~clk_i;

  sys_bus_xbar #(
    .N_SLAVES(NS), .DATA_W(DW), .SEL_MSB(31), .SEL_LSB(24),
    .TIMEOUT(TMO), .ERR_DATA(ERRD)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wd_i(wd_i), .be_i(be_i), .rd_o(rd_o),
    .ready_o(ready_o), .err_o(err_o), .s_req_o(s_req_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_wd_o(s_wd_o), .s_be_o(s_be_o),
    .s_rd_i(s_rd_i), .s_ready_i(s_ready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble_rd();
    for (int w = 0; w < NS; w++) s_rd_i[w*DW +: DW] = $urandom;
  endtask

  // One transaction. delay = BUSY cycles with the selected ready low before it
  // rises; noise_en marks other slaves allowed to toggle ready (forced high
  // every cycle when force_n is set). Called at #1 after an edge, DUT idle.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int delay, input logic [31:0] rdata,
                     input logic [7:0] noise_en, input bit force_n);
    int sel;
    bit mapped;
    int busy_n;
    bit exp_err;
    bit hit;
    logic [7:0] onehot;
    logic [7:0] noise;
    logic [31:0] cap;
    logic [31:0] rd_before;
    sel     = int'(addr[31:24]);
    mapped  = (sel < NS);
    busy_n  = !mapped ? 0 : (delay < TMO ? delay + 1 : TMO);
    exp_err = !mapped || (delay >= TMO);
    onehot  = mapped ? 8'(1 << sel) : 8'h00;
    cap     = ERRD;
    rd_before = rd_model;

    req_i = 1'b1; we_i = we; addr_i = addr; wd_i = wd; be_i = be;
    s_ready_i = 8'($urandom); scramble_rd();
    @(posedge clk_i); #1;
    req_i = 1'b0; we_i = $urandom; addr_i = $urandom; wd_i = $urandom; be_i = 4'($urandom);

    for (int c = 1; c <= busy_n + 1; c++) begin
      chk("s_req", 32'(s_req_o), (c <= busy_n) ? 32'(onehot) : 32'h0);
      chk("ready", 32'(ready_o), (c == busy_n + 1) ? 32'h1 : 32'h0);
      if (c == 1 && mapped) begin
        chk("s_addr", s_addr_o, {8'h00, addr[23:0]});
        chk("s_we", 32'(s_we_o), 32'(we));
        chk("s_wd", s_wd_o, wd);
        chk("s_be", 32'(s_be_o), 32'(be));
      end
      if (c <= busy_n) begin
        chk("rd_hold", rd_o, rd_before);
      end else begin
        if (!we) rd_model = exp_err ? ERRD : cap;
        chk("err", 32'(err_o), 32'(exp_err));
        chk("rd_done", rd_o, rd_model);
      end
      scramble_rd();
      hit   = mapped && (c <= busy_n) && (c == delay + 1);
      noise = noise_en & (force_n ? 8'hFF : 8'($urandom)) & ~onehot;
      s_ready_i = noise | (hit ? onehot : 8'h00);
      if (hit) begin
        s_rd_i[sel*DW +: DW] = rdata;
        cap = rdata;
      end
      @(posedge clk_i); #1;
    end
    chk("ready_after", 32'(ready_o), 32'h0);
    chk("s_req_after", 32'(s_req_o), 32'h0);
    ntxn++;
    $display("txn %0d we=%0d addr=%h delay=%0d err=%0d rd=%h", ntxn, we, addr, delay,
             exp_err, rd_model);
  endtask

  initial begin
    resetn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wd_i = '0; be_i = '0;
    s_rd_i = '0; s_ready_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_s_req", 32'(s_req_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_rd", rd_o, 32'h0);
    chk("rst_s_addr", s_addr_o, 32'h0);
    chk("rst_s_wd", s_wd_o, 32'h0);
    chk("rst_s_we_be", {27'h0, s_we_o, s_be_o}, 32'h0);
    resetn_i = 1'b1;
    @(posedge clk_i); #1;

    // Read slave 0, ready in first BUSY cycle.
    txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, 8'h00, 1'b0);
    // Write slave 6, ready after 3 BUSY cycles; rd_o must not change.
    txn(1'b1, 32'h0600_0004, 32'h0000_00A5, 4'b0001, 2, 32'h0BAD_0BAD, 8'h00, 1'b0);
    // Unmapped read and unmapped write.
    txn(1'b0, 32'h0900_0000, 32'h0, 4'hF, 0, 32'h0, 8'hFF, 1'b0);
    txn(1'b1, 32'hFF00_0008, 32'h5555_AAAA, 4'hC, 0, 32'h0, 8'hFF, 1'b0);
    // Timeout: selected slave never ready.
    txn(1'b0, 32'h0300_0020, 32'h0, 4'hF, 100, 32'h0, 8'h00, 1'b0);
    // Ready arriving in the last allowed BUSY cycle beats the timeout.
    txn(1'b0, 32'h0700_0040, 32'h0, 4'hF, TMO - 1, 32'hCAFE_F00D, 8'h00, 1'b0);
    // Slave 5 selected while slave 0 holds ready high throughout.
    txn(1'b0, 32'h0500_0100, 32'h0, 4'hF, 2, 32'h5A5A_0005, 8'h01, 1'b1);

    // Reset in the middle of a BUSY phase.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0200_0000; s_ready_i = '0;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    chk("rb_s_req1", 32'(s_req_o), 32'h04);
    @(posedge clk_i); #1;
    chk("rb_s_req2", 32'(s_req_o), 32'h04);
    resetn_i = 1'b0;
    @(posedge clk_i); #1;
    resetn_i = 1'b1;
    rd_model = '0;
    chk("rb_s_req", 32'(s_req_o), 32'h0);
    chk("rb_ready", 32'(ready_o), 32'h0);
    chk("rb_rd", rd_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      s_ready_i = 8'hFF;
      @(posedge clk_i); #1;
      chk("rb_no_ready", 32'(ready_o), 32'h0);
      chk("rb_idle_req", 32'(s_req_o), 32'h0);
    end
    s_ready_i = '0;
    $display("txn %0d reset during BUSY rd=%h", ntxn + 1, rd_model);
    ntxn++;

    // Random transactions.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      a = {8'($urandom_range(0, 10)), 24'($urandom)};
      txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 6)),
          $urandom, 8'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
